note_detect: RTL and testbench

NOTE_DETECT -- requirements
Module: note_detect

---
 rtl/note_detect.sv | 125 ++++++++++++
 tb/tb_note_detect.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/note_detect.sv
// Square-wave pitch detector: measures the period between synchronized rising edges of TONE_IN
// and reports a note once two consecutive periods classify the same.
module note_detect #(
    parameter int unsigned MIN_PERIOD = 180000,
    parameter int unsigned TIMEOUT    = 400000,
    parameter int unsigned C4_MIN     = 361375,
    parameter int unsigned D_MIN      = 321950,
    parameter int unsigned E_MIN      = 294857,
    parameter int unsigned F_MIN      = 270723,
    parameter int unsigned G_MIN      = 241188,
    parameter int unsigned A_MIN      = 214876,
    parameter int unsigned B_MIN      = 196796
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       TONE_IN,
    output logic [3:0] NOTE,
    output logic       NOTE_VALID,
    output logic       NOTE_STROBE
);

    localparam logic [19:0] TimeoutCnt = 20'(TIMEOUT);
    localparam logic [19:0] MinLo      = 20'(MIN_PERIOD);
    localparam logic [19:0] C4Lo       = 20'(C4_MIN);
    localparam logic [19:0] DLo        = 20'(D_MIN);
    localparam logic [19:0] ELo        = 20'(E_MIN);
    localparam logic [19:0] FLo        = 20'(F_MIN);
    localparam logic [19:0] GLo        = 20'(G_MIN);
    localparam logic [19:0] ALo        = 20'(A_MIN);
    localparam logic [19:0] BLo        = 20'(B_MIN);

    typedef enum logic {StIdle, StMeasure} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic        prev_q;
    logic        rise;
    logic [19:0] count_q, count_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  note_q, note_d;
    logic [3:0]  cls;
    logic        valid_q;
    logic        strobe_q;

    // Inclusive lower bounds, longest period (lowest pitch) first; 0 means invalid.
    function automatic logic [3:0] classify(input logic [19:0] p);
        if (p >= C4Lo)       return 4'd1;
        else if (p >= DLo)   return 4'd2;
        else if (p >= ELo)   return 4'd3;
        else if (p >= FLo)   return 4'd4;
        else if (p >= GLo)   return 4'd5;
        else if (p >= ALo)   return 4'd6;
        else if (p >= BLo)   return 4'd7;
        else if (p >= MinLo) return 4'd8;
        else                 return 4'd0;
    endfunction

    assign rise = sync_q[1] & ~prev_q;
    // The counter value on the edge cycle is the period just measured.
    assign cls  = classify(count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cand_d  = cand_q;
        note_d  = note_q;
        case (state_q)
            StIdle: begin
                count_d = '0;
                if (rise) begin
                    state_d = StMeasure;
                    count_d = 20'd1;
                end
            end
            StMeasure: begin
                if (rise) begin
                    count_d = 20'd1;
                    if (cls == 4'd0) begin
                        cand_d = 4'd0;
                        note_d = 4'd0;
                    end else if (cls == cand_q) begin
                        note_d = cls;
                    end else begin
                        cand_d = cls;
                    end
                end else if (count_q >= TimeoutCnt) begin
                    state_d = StIdle;
                    count_d = '0;
                    cand_d  = 4'd0;
                    note_d  = 4'd0;
                end else if (count_q != '1) begin
                    count_d = count_q + 20'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            state_q  <= StIdle;
            count_q  <= '0;
            cand_q   <= '0;
            note_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], TONE_IN};
            prev_q   <= sync_q[1];
            state_q  <= state_d;
            count_q  <= count_d;
            cand_q   <= cand_d;
            note_q   <= note_d;
            valid_q  <= (note_d != 4'd0);
            strobe_q <= (note_d != note_q);
        end
    end

    assign NOTE        = note_q;
    assign NOTE_VALID  = valid_q;
    assign NOTE_STROBE = strobe_q;

endmodule

// File: tb/tb_note_detect.sv
// Directed bench for note_detect with all period thresholds scaled down by 1000.
module tb_note_detect;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       TONE_IN;
    logic [3:0] NOTE;
    logic       NOTE_VALID;
    logic       NOTE_STROBE;

    int n_vec = 0;
    int n_err = 0;
    int strobes = 0;
    int base;

    note_detect #(
        .MIN_PERIOD(180), .TIMEOUT(400), .C4_MIN(361), .D_MIN(322), .E_MIN(295),
        .F_MIN(271), .G_MIN(241), .A_MIN(215), .B_MIN(197)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .TONE_IN    (TONE_IN),
        .NOTE       (NOTE),
        .NOTE_VALID (NOTE_VALID),
        .NOTE_STROBE(NOTE_STROBE)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (NOTE_STROBE) strobes++;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full period starting with a rising edge; called just after a falling clock edge.
    task automatic tone_period(input int p);
        TONE_IN = 1'b1;
        repeat (p / 2) @(negedge CLK);
        TONE_IN = 1'b0;
        repeat (p - p / 2) @(negedge CLK);
    endtask

    task automatic tone_run(input int p, input int n);
        for (int i = 0; i < n; i++) tone_period(p);
    endtask

    initial begin
        RESET_N = 1'b0;
        TONE_IN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_note", NOTE, 0);
        chk("rst_valid", NOTE_VALID, 0);
        chk("rst_strobe", NOTE_STROBE, 0);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rel_strobe", NOTE_STROBE, 0);
        repeat (4) @(negedge CLK);

        // A: two periods, then the third edge with exact timing.
        base = strobes;
        tone_run(227, 2);
        TONE_IN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("a_pre_note", NOTE, 0);
        chk("a_pre_strobe", NOTE_STROBE, 0);
        @(negedge CLK);
        chk("a_note", NOTE, 6);
        chk("a_valid", NOTE_VALID, 1);
        chk("a_strobe", NOTE_STROBE, 1);
        @(negedge CLK);
        chk("a_strobe_off", NOTE_STROBE, 0);
        repeat (113 - 4) @(negedge CLK);
        TONE_IN = 1'b0;
        repeat (114) @(negedge CLK);
        chk("a_strobes", strobes - base, 1);

        // C4 steady then C5: note holds through first C5 period.
        base = strobes;
        tone_run(382, 4);
        chk("c4_note", NOTE, 1);
        chk("c4_strobes", strobes - base, 1);
        base = strobes;
        tone_run(191, 2);
        chk("c5_first_note", NOTE, 1);
        tone_period(191);
        chk("c5_note", NOTE, 8);
        chk("c5_strobes", strobes - base, 1);

        // E steady, then silence until timeout.
        tone_run(303, 3);
        chk("e_note", NOTE, 3);
        base = strobes;
        TONE_IN = 1'b1;
        repeat (151) @(negedge CLK);
        TONE_IN = 1'b0;
        repeat (402 - 151) @(negedge CLK);
        chk("to_pre_note", NOTE, 3);
        chk("to_pre_strobe", NOTE_STROBE, 0);
        @(negedge CLK);
        chk("to_note", NOTE, 0);
        chk("to_valid", NOTE_VALID, 0);
        chk("to_strobe", NOTE_STROBE, 1);
        @(negedge CLK);
        chk("to_strobes", strobes - base, 1);

        // Edge arriving exactly at TIMEOUT counts as a C4 period.
        base = strobes;
        tone_run(400, 3);
        chk("edge_at_to_note", NOTE, 1);
        chk("edge_at_to_strobes", strobes - base, 1);

        // MIN_PERIOD is C5, one cycle shorter is invalid.
        base = strobes;
        tone_run(180, 3);
        chk("min_note", NOTE, 8);
        tone_run(179, 2);
        chk("below_min_note", NOTE, 0);
        chk("min_strobes", strobes - base, 2);

        // D steady, one invalid period, then D again.
        base = strobes;
        tone_run(330, 3);
        chk("d_note", NOTE, 2);
        tone_run(150, 2);
        chk("d_inv_note", NOTE, 0);
        chk("d_inv_valid", NOTE_VALID, 0);
        tone_run(330, 3);
        chk("d_again_note", NOTE, 2);
        chk("d_strobes", strobes - base, 3);

        // Alternating A/G periods never confirm.
        base = strobes;
        for (int i = 0; i < 3; i++) begin
            tone_period(240);
            tone_period(242);
        end
        chk("ga_note", NOTE, 2);
        chk("ga_strobes", strobes - base, 0);

        // F steady, then asynchronous reset mid-period.
        tone_run(280, 4);
        chk("f_note", NOTE, 4);
        chk("f_valid", NOTE_VALID, 1);
        TONE_IN = 1'b1;
        repeat (100) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_note", NOTE, 0);
        chk("arst_valid", NOTE_VALID, 0);
        chk("arst_strobe", NOTE_STROBE, 0);
        TONE_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        base = strobes;
        @(negedge CLK);
        chk("arst_rel_strobe", NOTE_STROBE, 0);
        tone_run(280, 2);
        chk("arst_two_edges_note", NOTE, 0);
        tone_period(280);
        chk("arst_note_back", NOTE, 4);
        chk("arst_strobes", strobes - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
